// File: rtl/l1_pkg.sv
// Shared constants and state encoding for the L1 register splice feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l1_pkg;

    localparam int         L1_NUM_BYTES = 24;
    localparam int         L1_SEL_W     = 5;
    localparam logic [7:0] L1_HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } l1_state_t;

endpackage

// File: rtl/l1_gap_timer.sv
// Idle-gap counter between accepted bytes inside a frame.
// Latency: expire is combinational from the registered count.
// Backpressure: none; counts whenever enabled and not cleared.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (wins over en)
//   en       : advance the count by one
//   expire   : count has reached TIMEOUT_CYC-1 while enabled
module l1_gap_timer #(
    parameter int TO_W        = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The owner leaves the timed states on expiry and clears us, so the
    // count never needs to saturate.
    assign expire = en && (cnt == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/l1_frame_loader.sv
// Frame parser feeding the 24-byte L1 splice registers: header, payload, checksum.
// Latency: one cycle from an accepted payload byte to its we/wdata/sel strobe.
// Backpressure: none; s_ready is high whenever reset is released.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_data/s_valid  : incoming byte stream; s_ready = !rst
//   wdata/sel/we    : one write strobe per payload byte, sel in arrival order
//   frame_ok        : one-cycle pulse, frame complete (checksum good if enabled)
//   frame_err       : one-cycle pulse, checksum mismatch or inter-byte timeout
//   busy            : combinational, high while inside a frame
//
// Build option L1_FRAME_LOADER_CHKSUM_EN: when defined a trailing checksum
// byte (payload sum mod 256) is expected and verified; when undefined the
// frame ends with the last payload byte and frame_ok accompanies its write.
module l1_frame_loader
    import l1_pkg::*;
#(
    parameter int         NUM_BYTES   = L1_NUM_BYTES,
    parameter int         SEL_W       = L1_SEL_W,
    parameter logic [7:0] HDR_BYTE    = L1_HDR_BYTE,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         TO_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       wdata,
    output logic [SEL_W-1:0] sel,
    output logic             we,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
`ifdef L1_FRAME_LOADER_CHKSUM_EN
    localparam logic [1:0] ST_CHECK   = CHECK;
`endif
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BYTES - 1);

    logic [1:0]       state;
    logic [SEL_W-1:0] idx;
`ifdef L1_FRAME_LOADER_CHKSUM_EN
    logic [7:0]       sum;
`endif
    logic             accept;
    logic             tmr_expire;
    logic             expired;

    assign s_ready = !rst;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);

    // An accepted byte in the expiry cycle rescues the frame.
    assign expired = tmr_expire && !accept;

    // Held at zero while idle so a new frame always starts with a fresh gap.
    l1_gap_timer #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || !busy),
        .en     (busy),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
`ifdef L1_FRAME_LOADER_CHKSUM_EN
            sum       <= '0;
`endif
            wdata     <= '0;
            sel       <= '0;
            we        <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            we        <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Anything other than the marker is line noise; drop it.
                    if (accept && (s_data == HDR_BYTE)) begin
                        state <= ST_PAYLOAD;
                        idx   <= '0;
`ifdef L1_FRAME_LOADER_CHKSUM_EN
                        sum   <= '0;
`endif
                    end
                end

                ST_PAYLOAD: begin
                    // The header value is ordinary data here; no resync.
                    if (accept) begin
                        wdata <= s_data;
                        sel   <= idx;
                        we    <= 1'b1;
                        idx   <= idx + 1'b1;
`ifdef L1_FRAME_LOADER_CHKSUM_EN
                        sum   <= sum + s_data;
                        if (idx == LAST_IDX) begin
                            state <= ST_CHECK;
                        end
`else
                        if (idx == LAST_IDX) begin
                            state    <= ST_IDLE;
                            frame_ok <= 1'b1;
                        end
`endif
                    end else if (expired) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end
                end

`ifdef L1_FRAME_LOADER_CHKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        state <= ST_IDLE;
                        if (s_data == sum) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (expired) begin
                        state     <= ST_IDLE;
                        frame_err <= 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_frame_loader.sv
// Directed bench for l1_frame_loader: framing, write strobes, timeout, reset.
// Latency: stimulus driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the DUT never stalls; s_ready is only checked around reset.
`timescale 1ns/1ps
module tb_l1_frame_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] wdata;
    logic [4:0] sel;
    logic       we;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    l1_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wdata     (wdata),
        .sel       (sel),
        .we        (we),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl [24];
    int last_cyc;
    int pl0_cyc;

    logic [7:0] wq_dat [$];
    logic [4:0] wq_sel [$];
    int         wq_cyc [$];
    int         ok_q   [$];
    int         err_q  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Event recorder: every strobe and pulse the DUT produces.
    always @(negedge clk) begin
        if (we) begin
            wq_dat.push_back(wdata);
            wq_sel.push_back(sel);
            wq_cyc.push_back(cyc);
        end
        if (frame_ok)  ok_q.push_back(cyc);
        if (frame_err) err_q.push_back(cyc);
        if (frame_ok && frame_err) chk("ok_err_excl", 32'd1, 32'd0);
    end

    task automatic clear_q();
        wq_dat.delete();
        wq_sel.delete();
        wq_cyc.delete();
        ok_q.delete();
        err_q.delete();
    endtask

    // Present one byte; returns 1 ns after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        last_cyc = cyc;
        s_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] ck);
        send(8'hA5);
        for (int i = 0; i < 24; i++) begin
            send(pl[i]);
            if (i == 0) pl0_cyc = last_cyc;
        end
`ifdef L1_FRAME_LOADER_CHKSUM_EN
        send(ck);
`else
        ck = ck;
`endif
    endtask

    task automatic verify(input string tag, input int n_we, input int n_ok, input int n_err);
        chk({tag, "_we_n"}, wq_dat.size(), n_we);
        for (int i = 0; i < n_we && i < wq_dat.size(); i++) begin
            chk($sformatf("%s_sel%0d", tag, i), wq_sel[i], i % 24);
            chk($sformatf("%s_dat%0d", tag, i), wq_dat[i], pl[i % 24]);
        end
        chk({tag, "_ok_n"},  ok_q.size(),  n_ok);
        chk({tag, "_err_n"}, err_q.size(), n_err);
    endtask

    initial begin
        int k;
        int f0;
        int f1;

        for (int i = 0; i < 24; i++) pl[i] = 8'(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we",        we,        1'b0);
        chk("rst_ok",        frame_ok,  1'b0);
        chk("rst_err",       frame_err, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_sel",       sel,       5'd0);
        chk("rst_wdata",     wdata,     8'd0);
        chk("rst_ready_low", s_ready,   1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_high", s_ready, 1'b1);
        idle(2);
        clear_q();

        // Good frame 00..17, checksum 0x14
        send(8'hA5);
        chk("good_busy_hdr", busy, 1'b1);
        for (int i = 0; i < 24; i++) begin
            send(pl[i]);
            if (i == 0) pl0_cyc = last_cyc;
        end
`ifdef L1_FRAME_LOADER_CHKSUM_EN
        send(8'h14);
`endif
        k = last_cyc;
        idle(3);
        verify("good", 24, 1, 0);
        chk("good_ok_cyc",  qget(ok_q, 0),   k);
        chk("good_lat1",    qget(wq_cyc, 0), pl0_cyc);
        chk("good_busy_end", busy, 1'b0);

`ifdef L1_FRAME_LOADER_CHKSUM_EN
        // Bad checksum
        clear_q();
        send_frame(8'h15);
        k = last_cyc;
        idle(3);
        verify("badck", 24, 0, 1);
        chk("badck_err_cyc", qget(err_q, 0), k);
        chk("badck_busy", busy, 1'b0);
`endif

        // Junk before frame, header value inside payload (sum becomes 0xB6)
        clear_q();
        send(8'h11);
        send(8'h22);
        chk("junk_busy", busy, 1'b0);
        pl[3] = 8'hA5;
        send_frame(8'hB6);
        idle(3);
        verify("junk", 24, 1, 0);
        pl[3] = 8'h03;

        // Timeout after payload byte 10
        clear_q();
        send(8'hA5);
        for (int i = 0; i < 11; i++) send(pl[i]);
        k = last_cyc;
        idle(500);
        chk("tmo_busy_mid", busy, 1'b1);
        idle(530);
        verify("tmo", 11, 0, 1);
        chk("tmo_err_cyc", qget(err_q, 0), k + 1024);
        chk("tmo_busy", busy, 1'b0);

        // Byte lands exactly on the expiry cycle
        clear_q();
        send(8'hA5);
        for (int i = 0; i < 11; i++) send(pl[i]);
        k = last_cyc;
        idle(1023);
        for (int i = 11; i < 24; i++) send(pl[i]);
`ifdef L1_FRAME_LOADER_CHKSUM_EN
        send(8'h14);
`endif
        idle(3);
        verify("edge", 24, 1, 0);
        chk("edge_we_cyc", qget(wq_cyc, 11), k + 1024);

        // Reset in the middle of a frame, then a clean frame
        clear_q();
        send(8'hA5);
        for (int i = 0; i < 12; i++) send(pl[i]);
        rst = 1'b1;
        idle(2);
        chk("mrst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(2);
        chk("mrst_err_n", err_q.size(), 0);
        chk("mrst_we_n",  wq_dat.size(), 12);
        clear_q();
        send_frame(8'h14);
        idle(3);
        verify("post_rst", 24, 1, 0);

        // Back-to-back frames
        clear_q();
        send_frame(8'h14);
        f0 = last_cyc;
        send_frame(8'h14);
        f1 = last_cyc;
        idle(3);
        verify("b2b", 48, 2, 0);
        chk("b2b_ok0_cyc", qget(ok_q, 0), f0);
        chk("b2b_ok1_cyc", qget(ok_q, 1), f1);
`ifndef L1_FRAME_LOADER_CHKSUM_EN
        chk("b2b_ok0_we23", qget(ok_q, 0), qget(wq_cyc, 23));
        chk("b2b_ok1_we47", qget(ok_q, 1), qget(wq_cyc, 47));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
